log2_share_sched: RTL and testbench
===================================

Name: log2_share_sched

Overview:
- Schedules one shared 64-bit fixed-point log2 pipeline across N requesters, for example per-antenna RSSI or energy channels.
- Arbitrates round-robin among pending requests and drives the log2 unit's input register.
- Tracks each in-flight operand with a channel tag through the fixed pipeline latency.
- Captures results into an output FIFO with valid/ready handshake. Credit gating guarantees no result is ever lost, because the log2 pipeline cannot stall.

Parameters:
- N_CH, 4, number of requesters (2..16).
- DIN_WIDTH, 64, operand width fed to the log2 unit.
- DOUT_WIDTH, 10, log2 result width (6 integer + 4 fraction bits).
- LATENCY, 3, clock edges from the log2 unit sampling its input to its result being valid.
- FIFO_DEPTH, 8, result FIFO entries; must be >= LATENCY+2 and a power of two.
- CH_W, 2, channel tag width, equal to clog2(N_CH).

Ports:
- clk  in  1  Single system clock.
- rst_n  in  1  Reset: one clock, asynchronous assert, active-low.
- en  in  1  When low, no new grants; in-flight work drains normally.
- req_valid  in  N_CH  Per-channel request valid.
- req_data  in  N_CH*DIN_WIDTH  Per-channel operand; channel k occupies [k*DIN_WIDTH +: DIN_WIDTH].
- req_ready  out  N_CH  One-hot grant; a transfer occurs when req_valid[k]&req_ready[k].
- log_din  out  DIN_WIDTH  Registered operand to the log2 unit's input.
- log_dout  in  DOUT_WIDTH  Result from the log2 unit.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  Consumer accepts the head entry.
- res_data  out  DOUT_WIDTH  Head entry result.
- res_chan  out  CH_W  Head entry channel tag.
- busy  out  1  Any in-flight tag or FIFO non-empty.

Behaviour:
- Reset values: log_din=0, tag pipe all invalid, FIFO empty, rr pointer=N_CH-1 (so channel 0 wins first), res_valid=0, busy=0, req_ready=0.
- Grant condition (combinational): en=1, at least one req_valid, and fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of valid stages in the tag pipe.
  - A same-cycle pop is not credited; credits are conservative.
- Winner selection:
  - The first asserted req_valid searching from rr_ptr+1 upward, wrapping modulo N_CH.
  - req_ready is one-hot on the winner only, and all zero when the grant condition fails.
  - req_ready is not asserted for channels with req_valid low.
- On a transfer edge:
  - log_din <= the winner's operand.
  - rr_ptr <= winner.
  - Tag stage0 <= {1, winner}.
- With no transfer, log_din holds its value and stage0 is written invalid.
- Tag pipe: LATENCY+1 stages.
  - Stage0 aligns with log_din; stage LATENCY aligns with log_dout being valid for that operand.
  - Shifts every cycle, unconditionally.
  - A grant at edge T produces a FIFO push at edge T+LATENCY+1; the entry is visible on res_* in cycle T+LATENCY+2. With LATENCY=3 the total is 5 cycles from acceptance to res_valid.
- FIFO push: when stage LATENCY is valid, push {log_dout, tag}.
- FIFO pop: on res_valid & res_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Push-when-full cannot occur because of the grant credit rule. An assertion must flag it if it does.
- FIFO is show-ahead: res_data and res_chan reflect the head entry while res_valid=1. They are don't-care when empty.
- Pointers wrap modulo FIFO_DEPTH; the count field is clog2(FIFO_DEPTH)+1 bits.
- Sustained throughput: one grant per cycle while the consumer keeps up. A stalled consumer halts grants within the credit window.
- en deasserted mid-stream: no new grants; in-flight results still land in the FIFO; busy falls once everything is drained.
- Reset asserted mid-operation: all tags and FIFO contents are discarded immediately (asynchronously) and no partial results emerge. The log2 unit's stale output is ignored because all tags are invalid.
- Channels whose req_valid stays high keep it high across stalls; the block never drops a request that was granted.

Test Plan:
- Single request: channel 2 sends 1024 (integer, 0 fraction bits) → req_ready[2] pulses once; 5 cycles later res_valid=1, res_data=160 (10<<4), res_chan=2.
- Round-robin fairness: all 4 channels valid continuously with operands 1, 2, 4, 8 → grant order 0,1,2,3,0,…; results 0, 16, 32, 48 emerge in that order with matching tags.
- Backpressure: res_ready=0 with all channels requesting → exactly 8 grants issued, then req_ready=0. FIFO ends full with 8 entries and no loss. Raising res_ready resumes grants within one cycle of the first pop.
- Simultaneous push and pop at steady state with res_ready=1 → fifo_count stays constant, one result per cycle, no ordering errors.
- en drop: deassert en with 3 ops in flight → no further grants; the 3 results arrive; busy falls after the FIFO is drained.
- Async reset pulse between clock edges with 2 in flight and 4 queued → outputs return to reset values immediately; after release there are no stale res_valid pulses and the first grant goes to channel 0.

Source files
------------

// File: rtl/log2_share_sched_if.sv
// Request/result bundle between the requesters, the log2 scheduler and the result consumer.
interface log2_share_sched_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIN_WIDTH  = 64,
  parameter int unsigned DOUT_WIDTH = 10,
  parameter int unsigned CH_W       = $clog2(N_CH)
) ();

  logic [N_CH-1:0]           req_valid;
  logic [N_CH*DIN_WIDTH-1:0] req_data;
  logic [N_CH-1:0]           req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [DOUT_WIDTH-1:0]     res_data;
  logic [CH_W-1:0]           res_chan;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_chan
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_chan
  );

endinterface

// File: rtl/log2_share_sched.sv
// Round-robin scheduler sharing one fixed-latency log2 pipeline across N_CH requesters,
// with channel tagging through the pipe and a credit-gated show-ahead result FIFO.
module log2_share_sched #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DIN_WIDTH  = 64,
  parameter int unsigned DOUT_WIDTH = 10,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CH_W       = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [DIN_WIDTH-1:0]  log_din,
  input  logic [DOUT_WIDTH-1:0] log_dout,
  output logic                  busy,
  log2_share_sched_if.slave     bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DOUT_WIDTH + CH_W;

  logic [CH_W-1:0]             rr_ptr;
  logic [CH_W-1:0]             winner;
  logic [CH_W-1:0]             rr_idx;
  logic                        found;
  logic                        grant_ok;
  logic                        xfer;
  logic                        push;
  logic                        pop;
  logic [N_CH-1:0]             req_ready_c;
  logic [LATENCY:0]            tag_vld;
  logic [LATENCY:0][CH_W-1:0]  tag_ch;
  logic [CNT_W-1:0]            inflight;
  logic [CNT_W-1:0]            fifo_count;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [ENT_W-1:0]            mem [FIFO_DEPTH];

  // First pending channel searching upward from the one after the last winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      rr_idx = CH_W'((32'(rr_ptr) + i) % N_CH);
      if (!found && bus.req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int unsigned s = 0; s <= LATENCY; s++) begin
      inflight = inflight + CNT_W'(tag_vld[s]);
    end
  end

  // Every granted operand must already own a FIFO slot; pops in the same cycle are not credited.
  always_comb begin
    grant_ok    = en && found &&
                  ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight) < (CNT_W+1)'(FIFO_DEPTH));
    req_ready_c = '0;
    if (grant_ok) begin
      req_ready_c[winner] = 1'b1;
    end
  end

  assign xfer          = |(bus.req_valid & req_ready_c);
  assign bus.req_ready = req_ready_c;
  assign push          = tag_vld[LATENCY];
  assign pop           = bus.res_valid && bus.res_ready;
  assign bus.res_valid = (fifo_count != '0);
  assign busy          = (|tag_vld) || bus.res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_din    <= '0;
      rr_ptr     <= CH_W'(N_CH - 1);
      tag_vld    <= '0;
      tag_ch     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (xfer) begin
        log_din <= bus.req_data[32'(winner) * DIN_WIDTH +: DIN_WIDTH];
        rr_ptr  <= winner;
      end
      tag_vld <= {tag_vld[LATENCY-1:0], xfer};
      tag_ch  <= {tag_ch[LATENCY-1:0], winner};
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {log_dout, tag_ch[LATENCY]};
    end
  end

  assign {bus.res_data, bus.res_chan} = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == CNT_W'(FIFO_DEPTH)))
    else $error("log2_share_sched: result pushed into a full FIFO");

endmodule

// File: tb/tb_log2_share_sched.sv
// Scoreboard bench for log2_share_sched: grants push expected results, a monitor pops and compares.
module tb_log2_share_sched;

  localparam int unsigned N_CH       = 4;
  localparam int unsigned DIN_WIDTH  = 64;
  localparam int unsigned DOUT_WIDTH = 10;
  localparam int unsigned LATENCY    = 3;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned ENT_W      = DOUT_WIDTH + CH_W;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic [DIN_WIDTH-1:0]  log_din;
  logic [DOUT_WIDTH-1:0] log_dout;
  logic                  busy;

  log2_share_sched_if #(.N_CH(N_CH), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .CH_W(CH_W)) bus ();

  log2_share_sched #(
    .N_CH(N_CH), .DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH),
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .log_din(log_din),
    .log_dout(log_dout), .busy(busy), .bus(bus)
  );

  // Behavioural log2 unit: integer part = msb index, fraction = next 4 bits below it.
  function automatic logic [DOUT_WIDTH-1:0] flog2(input logic [DIN_WIDTH-1:0] x);
    int msb;
    logic [DIN_WIDTH-1:0] t;
    msb = 0;
    for (int i = 0; i < DIN_WIDTH; i++) if (x[i]) msb = i;
    if (msb >= 4) t = x >> (msb - 4);
    else          t = x << (4 - msb);
    return {6'(msb), t[3:0]};
  endfunction

  logic [DOUT_WIDTH-1:0] lp [LATENCY];
  always @(posedge clk) begin
    lp[0] <= flog2(log_din);
    for (int i = 1; i < LATENCY; i++) lp[i] <= lp[i-1];
  end
  assign log_dout = lp[LATENCY-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int gcount   = 0;
  int cyc      = 0;
  int rr_exp   = 0;
  bit chk_rr   = 1'b0;
  logic [ENT_W-1:0]      sb [$];
  logic [DOUT_WIDTH-1:0] exp_res [N_CH];

  logic [DIN_WIDTH-1:0]  ops_tbl [N_CH] = '{64'd1, 64'd2, 64'd4, 64'd8};
  logic [DOUT_WIDTH-1:0] exp_tbl [N_CH] = '{10'd0, 10'd16, 10'd32, 10'd48};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: grant capture feeds the scoreboard; result handshakes pop and compare.
  int mon_w;
  logic [ENT_W-1:0] ent;
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      check("req_ready_only_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
      mon_w = -1;
      for (int i = 0; i < N_CH; i++) if (bus.req_ready[i] && bus.req_valid[i]) mon_w = i;
      if (mon_w >= 0) begin
        gcount++;
        sb.push_back({exp_res[mon_w], CH_W'(mon_w)});
        if (chk_rr) begin
          check("rr_order", 64'(mon_w), 64'(rr_exp));
          rr_exp = (rr_exp + 1) % N_CH;
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          ent = sb.pop_front();
          check("res_data", 64'(bus.res_data), 64'(ent[ENT_W-1:CH_W]));
          check("res_chan", 64'(bus.res_chan), 64'(ent[CH_W-1:0]));
        end
      end
    end
  end

  task automatic load_all_ops();
    for (int i = 0; i < N_CH; i++) begin
      bus.req_data[i*DIN_WIDTH +: DIN_WIDTH] = ops_tbl[i];
      exp_res[i] = exp_tbl[i];
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    gcount = 0;
    rr_exp = 0;
    chk_rr = 1'b0;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int bound);
    int n;
    n = 0;
    while (gcount < target && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("grant_target_reached", 64'(gcount >= target), 64'd1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int stale;
    bit seen;
    rst_n         = 1'b0;
    en            = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) exp_res[i] = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_log_din", log_din, 64'd0);

    // Single request on channel 2: log2(1024) = 10.0 -> 160
    do_reset();
    bus.req_data[2*DIN_WIDTH +: DIN_WIDTH] = 64'd1024;
    exp_res[2] = 10'd160;
    bus.req_valid = 4'b0100;
    seen = 1'b0;
    c0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin
        seen = 1'b1;
        c0 = cyc;
        break;
      end
    end
    check("single_grant_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("single_res_seen", 64'(seen), 64'd1);
    check("single_latency", 64'(cyc - c0), 64'd5);
    wait_idle("single", 30);
    check("single_grant_count", 64'(gcount), 64'd1);

    // Round-robin fairness and one-per-cycle throughput
    do_reset();
    load_all_ops();
    chk_rr = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'hF;
    c0 = cyc;
    wait_grants(12, 40);
    check("rr_throughput_cycles", 64'(cyc - c0), 64'd12);
    bus.req_valid = '0;
    wait_idle("rr", 30);
    check("rr_grant_count", 64'(gcount), 64'd12);

    // Backpressure: stalled consumer caps grants at FIFO depth
    do_reset();
    load_all_ops();
    chk_rr = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_valid = 4'hF;
    repeat (30) @(posedge clk);
    #1;
    check("bp_grant_count", 64'(gcount), 64'd8);
    check("bp_req_ready_zero", 64'(bus.req_ready), 64'd0);
    check("bp_res_valid", 64'(bus.res_valid), 64'd1);
    check("bp_sb_depth", 64'(sb.size()), 64'd8);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_still_full", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check("bp_resume", 64'(bus.req_ready != 0), 64'd1);
    wait_grants(16, 40);
    bus.req_valid = '0;
    wait_idle("bp", 40);

    // en dropped with three operations in flight
    do_reset();
    load_all_ops();
    chk_rr = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'hF;
    wait_grants(3, 20);
    en = 1'b0;
    check("en_busy_inflight", 64'(busy), 64'd1);
    @(negedge clk);
    check("en_req_ready_zero", 64'(bus.req_ready), 64'd0);
    wait_idle("en", 30);
    check("en_grant_count", 64'(gcount), 64'd3);
    bus.req_valid = '0;
    en = 1'b1;

    // Async reset with 2 in flight and 4 queued
    do_reset();
    load_all_ops();
    chk_rr = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_valid = 4'hF;
    wait_grants(6, 20);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check("ar_pre_busy", 64'(busy), 64'd1);
    check("ar_pre_res_valid", 64'(bus.res_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_res_valid", 64'(bus.res_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_req_ready", 64'(bus.req_ready), 64'd0);
    check("ar_log_din", log_din, 64'd0);
    sb.delete();
    gcount = 0;
    rr_exp = 0;
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid) stale++;
    end
    check("ar_no_stale_results", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    wait_grants(4, 20);
    bus.req_valid = '0;
    wait_idle("ar", 30);
    check("ar_grant_count", 64'(gcount), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
